// File: rtl/dac_gain_precompensator.sv
// Per-lane gain scaling, rounding and saturation for the DAC AXI-stream, with frame-aligned gain updates.
// Optional build macro DAC_DITHER_EN replaces the constant rounding term with LFSR dither.
module dac_gain_precompensator #(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned GAIN_WIDTH    = 16,
    parameter int unsigned GAIN_FRAC     = 8,
    parameter int unsigned SAT_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    pre_dac_tdata,
    input  logic                     pre_dac_tvalid,
    output logic                     pre_dac_tready,
    input  logic                     pre_dac_tlast,
    input  logic [GAIN_WIDTH-1:0]    gain,
    input  logic                     gain_load,
    output logic [GAIN_WIDTH-1:0]    gain_active,
    output logic [DATA_WIDTH-1:0]    post_dac_tdata,
    output logic                     post_dac_tvalid,
    input  logic                     post_dac_tready,
    output logic                     post_dac_tlast,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);

    localparam int unsigned LANES  = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned PROD_W = 8 + GAIN_WIDTH + 1;
    localparam int unsigned BYTE_W = LANES * 8;
    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY  = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic [PROD_W-1:0]     ROUND_CONST = PROD_W'(1) << (GAIN_FRAC - 1);
    localparam logic [PROD_W-1:0]     BYTE_MAX    = PROD_W'(255);

    logic stall_c;
    logic accept_c;

    logic [GAIN_WIDTH-1:0] gain_active_q, gain_active_d;
    logic [GAIN_WIDTH-1:0] gain_pend_q,   gain_pend_d;
    logic                  pend_valid_q,  pend_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic [GAIN_WIDTH-1:0] gain_use_c;
    logic [PROD_W-1:0]     round_c;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [BYTE_W-1:0] s1_byte_q,  s1_byte_d;
    logic [LANES-1:0]  s1_sat_q,   s1_sat_d;
    logic [BYTE_W-1:0] lane_byte_c;
    logic [LANES-1:0]  lane_sat_c;

    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q,  out_last_d;
    logic [DATA_WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q,   sat_cnt_d;

    logic unused_tdata_c;

    assign stall_c        = out_valid_q && !post_dac_tready;
    assign accept_c       = pre_dac_tvalid && !stall_c;
    assign pre_dac_tready = !stall_c;
    assign unused_tdata_c = ^pre_dac_tdata;

    assign gain_active     = gain_active_q;
    assign post_dac_tdata  = out_data_q;
    assign post_dac_tvalid = out_valid_q;
    assign post_dac_tlast  = out_last_q;
    assign sat_count       = sat_cnt_q;

`ifdef DAC_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // x^16 + x^14 + x^13 + x^11 + 1, advanced once per accepted beat
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept_c) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign round_c = PROD_W'(lfsr_q[GAIN_FRAC-1:0]);
`else
    assign round_c = ROUND_CONST;
`endif

    // A frame-start beat picks up the pending gain before this cycle's strobe is captured
    assign gain_use_c = (frame_start_q && pend_valid_q) ? gain_pend_q : gain_active_q;

    always_comb begin
        gain_active_d = gain_active_q;
        gain_pend_d   = gain_pend_q;
        pend_valid_d  = pend_valid_q;
        frame_start_d = frame_start_q;
        if (accept_c) begin
            frame_start_d = pre_dac_tlast;
            if (frame_start_q && pend_valid_q) begin
                gain_active_d = gain_pend_q;
                pend_valid_d  = 1'b0;
            end
        end
        if (gain_load) begin
            gain_pend_d  = gain;
            pend_valid_d = 1'b1;
        end
    end

    // Per-lane multiply, round and clip to one byte
    always_comb begin : lane_math
        logic [PROD_W-1:0] scaled;
        lane_byte_c = '0;
        lane_sat_c  = '0;
        scaled      = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            scaled = (PROD_W'(pre_dac_tdata[i*WORD_WIDTH +: 8]) * PROD_W'(gain_use_c)
                      + round_c) >> GAIN_FRAC;
            if (scaled > BYTE_MAX) begin
                lane_byte_c[i*8 +: 8] = 8'hFF;
                lane_sat_c[i]         = 1'b1;
            end else begin
                lane_byte_c[i*8 +: 8] = scaled[7:0];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_byte_d  = s1_byte_q;
        s1_sat_d   = s1_sat_q;
        if (!stall_c) begin
            s1_valid_d = pre_dac_tvalid;
            s1_last_d  = pre_dac_tvalid && pre_dac_tlast;
            s1_byte_d  = pre_dac_tvalid ? lane_byte_c : '0;
            s1_sat_d   = pre_dac_tvalid ? lane_sat_c  : '0;
        end
    end

    // Output stage: place each byte in the top of its DAC word and count saturated beats
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        sat_cnt_d   = sat_cnt_q;
        if (!stall_c) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            out_data_d  = '0;
            for (int i = 0; i < int'(LANES); i++) begin
                out_data_d[i*WORD_WIDTH +: WORD_WIDTH] =
                    WORD_WIDTH'(s1_byte_q[i*8 +: 8]) << (WORD_WIDTH - 8);
            end
            if (s1_valid_q && (|s1_sat_q) && (sat_cnt_q != '1)) begin
                sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_active_q <= GAIN_UNITY;
            gain_pend_q   <= '0;
            pend_valid_q  <= 1'b0;
            frame_start_q <= 1'b1;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_byte_q     <= '0;
            s1_sat_q      <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            sat_cnt_q     <= '0;
        end else begin
            gain_active_q <= gain_active_d;
            gain_pend_q   <= gain_pend_d;
            pend_valid_q  <= pend_valid_d;
            frame_start_q <= frame_start_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s1_byte_q     <= s1_byte_d;
            s1_sat_q      <= s1_sat_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
            sat_cnt_q     <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_dac_gain_precompensator.sv
// Randomized and directed bench for dac_gain_precompensator against a frame-level gain/scoreboard model.
module tb_dac_gain_precompensator;

    localparam int unsigned DW    = 256;
    localparam int unsigned WW    = 16;
    localparam int unsigned LANES = DW / WW;
    localparam int unsigned GW    = 16;
    localparam int unsigned GF    = 8;
    localparam int unsigned SW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pre_dac_tdata;
    logic          pre_dac_tvalid;
    logic          pre_dac_tready;
    logic          pre_dac_tlast;
    logic [GW-1:0] gain;
    logic          gain_load;
    logic [GW-1:0] gain_active;
    logic [DW-1:0] post_dac_tdata;
    logic          post_dac_tvalid;
    logic          post_dac_tready;
    logic          post_dac_tlast;
    logic [SW-1:0] sat_count;

    always #5 clk = ~clk;

    dac_gain_precompensator #(
        .DATA_WIDTH(DW), .WORD_WIDTH(WW), .GAIN_WIDTH(GW), .GAIN_FRAC(GF), .SAT_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_dac_tdata(pre_dac_tdata), .pre_dac_tvalid(pre_dac_tvalid),
        .pre_dac_tready(pre_dac_tready), .pre_dac_tlast(pre_dac_tlast),
        .gain(gain), .gain_load(gain_load), .gain_active(gain_active),
        .post_dac_tdata(post_dac_tdata), .post_dac_tvalid(post_dac_tvalid),
        .post_dac_tready(post_dac_tready), .post_dac_tlast(post_dac_tlast),
        .sat_count(sat_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: gain bookkeeping at frame level plus a queue of expected output beats
    int            m_active;
    int            m_pend;
    bit            m_pv;
    bit            m_fs;
    int            m_sat;
    logic [DW:0]   exp_q[$];
    logic [WW-1:0] last_word0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill_beat(input int x);
        logic [DW-1:0] d;
        for (int i = 0; i < int'(LANES); i++) begin
            d[i*WW +: WW] = {8'($urandom), 8'(x)};
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(LANES); i++) d[i*WW +: WW] = WW'($urandom);
        return d;
    endfunction

    function automatic logic [DW-1:0] scale_beat(input logic [DW-1:0] d, input int g, output bit sat);
        logic [DW-1:0] e;
        int x, r;
        sat = 1'b0;
        e   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            x = int'(d[i*WW +: 8]);
            r = (x * g + (1 << (GF - 1))) / (1 << GF);
            if (r > 255) begin
                r   = 255;
                sat = 1'b1;
            end
            e[i*WW +: WW] = WW'(r * 256);
        end
        return e;
    endfunction

    task automatic model_reset();
        m_active = 1 << GF;
        m_pend   = 0;
        m_pv     = 1'b0;
        m_fs     = 1'b1;
        m_sat    = 0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, check handshakes, update model, advance to next negedge
    task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit rdy,
                        input bit ld, input logic [GW-1:0] g);
        logic [DW:0]   e;
        logic [DW-1:0] sc;
        bit            sat;
        int            g_use;
        pre_dac_tvalid  = v;
        pre_dac_tdata   = d;
        pre_dac_tlast   = l;
        post_dac_tready = rdy;
        gain_load       = ld;
        gain            = g;
        #1;
        check_val("tready", DW'(pre_dac_tready), DW'(!(post_dac_tvalid && !rdy)));
        check_val("gain_active", DW'(gain_active), DW'(m_active));
        if (post_dac_tvalid && rdy) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_beat", DW'(1), DW'(0));
            end else begin
                e = exp_q.pop_front();
                check_val("out_data", post_dac_tdata, e[DW-1:0]);
                check_val("out_last", DW'(post_dac_tlast), DW'(e[DW]));
                last_word0 = post_dac_tdata[WW-1:0];
            end
        end
        if (v && !(post_dac_tvalid && !rdy)) begin
            g_use = m_active;
            if (m_fs && m_pv) begin
                g_use    = m_pend;
                m_active = m_pend;
                m_pv     = 1'b0;
            end
            sc = scale_beat(d, g_use, sat);
            if (sat) m_sat++;
            exp_q.push_back({l, sc});
            m_fs = l;
        end
        if (ld) begin
            m_pend = int'(g);
            m_pv   = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic drain(input string tag);
        idle(4);
        check_val({tag, "_drained"}, DW'(exp_q.size()), DW'(0));
        check_val({tag, "_sat_count"}, DW'(sat_count), DW'(m_sat));
    endtask

    task automatic do_reset(input string tag);
        pre_dac_tvalid  = 1'b0;
        gain_load       = 1'b0;
        post_dac_tready = 1'b1;
        rst_n           = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_tvalid"}, DW'(post_dac_tvalid), DW'(0));
        check_val({tag, "_tdata"}, post_dac_tdata, DW'(0));
        check_val({tag, "_gain"}, DW'(gain_active), DW'(16'h0100));
        check_val({tag, "_sat"}, DW'(sat_count), DW'(0));
        check_val({tag, "_tready"}, DW'(pre_dac_tready), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [DW-1:0] d;
        int            sat0;
        rst_n           = 1'b0;
        pre_dac_tdata   = '0;
        pre_dac_tvalid  = 1'b0;
        pre_dac_tlast   = 1'b0;
        post_dac_tready = 1'b1;
        gain            = '0;
        gain_load       = 1'b0;
        last_word0      = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_reset("rst0");

        // Unity gain, lanes 0x00/0x7F/0xFF, two-cycle latency
        d = rand_beat();
        d[0*WW +: 8] = 8'h00;
        d[1*WW +: 8] = 8'h7F;
        d[2*WW +: 8] = 8'hFF;
        step(1'b1, d, 1'b1, 1'b1, 1'b0, '0);
        check_val("t1_lat1_valid", DW'(post_dac_tvalid), DW'(0));
        idle(1);
        check_val("t1_lat2_valid", DW'(post_dac_tvalid), DW'(1));
        check_val("t1_lane0", DW'(post_dac_tdata[0*WW +: WW]), DW'(16'h0000));
        check_val("t1_lane1", DW'(post_dac_tdata[1*WW +: WW]), DW'(16'h7F00));
        check_val("t1_lane2", DW'(post_dac_tdata[2*WW +: WW]), DW'(16'hFF00));
        drain("t1");

        // Mid-frame gain load takes effect on the next frame
        step(1'b1, fill_beat(100), 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 16'h0180);
        step(1'b1, fill_beat(100), 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, fill_beat(100), 1'b1, 1'b1, 1'b0, '0);
        idle(3);
        check_val("t2_old_gain_word", DW'(last_word0), DW'(16'h6400));
        check_val("t2_gain_before", DW'(gain_active), DW'(16'h0100));
        step(1'b1, fill_beat(100), 1'b1, 1'b1, 1'b0, '0);
        check_val("t2_gain_after", DW'(gain_active), DW'(16'h0180));
        drain("t2");
        check_val("t2_new_gain_word", DW'(last_word0), DW'(16'h9600));

        // Saturation and the saturated-beat counter
        sat0 = int'(sat_count);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 16'h0200);
        step(1'b1, fill_beat(200), 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, fill_beat(127), 1'b0, 1'b1, 1'b0, '0);
        idle(3);
        check_val("t3_unsat_word", DW'(last_word0), DW'(16'hFE00));
        step(1'b1, fill_beat(200), 1'b1, 1'b1, 1'b0, '0);
        drain("t3");
        check_val("t3_sat_word", DW'(last_word0), DW'(16'hFF00));
        check_val("t3_sat_incr", DW'(sat_count), DW'(sat0 + 2));

        // Gain strobe coincident with a frame-start accept waits for the following frame
        step(1'b1, fill_beat(100), 1'b1, 1'b1, 1'b1, 16'h0080);
        drain("t5a");
        check_val("t5_old_gain_word", DW'(last_word0), DW'(16'hC800));
        step(1'b1, fill_beat(100), 1'b1, 1'b1, 1'b0, '0);
        drain("t5b");
        check_val("t5_new_gain_word", DW'(last_word0), DW'(16'h3200));

        // Random traffic with backpressure, including a five-cycle ready-low window
        for (int c = 0; c < 1400; c++) begin
            bit v, rdy, ld;
            v   = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 15) == 0);
            if (c >= 300 && c < 305) begin
                v   = 1'b1;
                rdy = 1'b0;
            end
            step(v, rand_beat(), ($urandom_range(0, 7) == 0), rdy, ld,
                 GW'($urandom_range(0, 16'h0300)));
        end
        drain("t4");

        // Reset with beats in flight flushes them
        step(1'b1, fill_beat(50), 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, fill_beat(60), 1'b0, 1'b1, 1'b0, '0);
        do_reset("t6");
        idle(3);
        check_val("t6_no_output", DW'(post_dac_tvalid), DW'(0));
        step(1'b1, fill_beat(10), 1'b1, 1'b1, 1'b0, '0);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
